// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory/writeback stage.
//   memwb_state_t : stage FSM states
//   op_class_t    : instruction class resolved from the EX control flags
//   decode_op     : fixed-priority flag decode (memread > memwrite >
//                   bustoreg > buswrite > regwrite)
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        BUS_REQ   = 2'd2,
        BUS_RSP   = 2'd3
    } memwb_state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_BUSRD = 3'd4,
        OP_BUSWR = 3'd5
    } op_class_t;

    // Lower-priority flags are ignored once a higher one is set.
    function automatic op_class_t decode_op(input logic regwrite, input logic memread,
                                            input logic memwrite, input logic bustoreg,
                                            input logic buswrite);
        if (memread)       return OP_LOAD;
        else if (memwrite) return OP_STORE;
        else if (bustoreg) return OP_BUSRD;
        else if (buswrite) return OP_BUSWR;
        else if (regwrite) return OP_ALU;
        else               return OP_NONE;
    endfunction

endpackage

// File: rtl/cpu_memwb_unit_if.sv
// Accelerator bus between the memory/writeback stage (master) and the
// accelerator channels (slave).
//   bus_req_valid/ready/write/ch/data : request channel
//   bus_rsp_valid/data                : read response (no backpressure)
// Handshake: a request transfers on a clock edge where bus_req_valid and
// bus_req_ready are both high; while valid is high and ready is low the
// master holds write/ch/data stable. A read response transfers on any edge
// where bus_rsp_valid is high while the master is waiting for it.
interface cpu_memwb_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = 2
);
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_req_write;
    logic [CH_W-1:0]   bus_req_ch;
    logic [DATA_W-1:0] bus_req_data;
    logic              bus_rsp_valid;
    logic [DATA_W-1:0] bus_rsp_data;

    modport master (
        output bus_req_valid, bus_req_write, bus_req_ch, bus_req_data,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data
    );

    modport slave (
        input  bus_req_valid, bus_req_write, bus_req_ch, bus_req_data,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data
    );
endinterface

// File: rtl/cpu_bus_master.sv
// Accelerator bus master: request handshake, response wait, timeout
// counter and bad-channel detection. The parent FSM tells it which phase
// it is in; it reports back when the op completes.
//   start_i/start_write_i/start_ch_i/start_data_i : launch a bus op
//   in_req_i / in_rsp_i : parent is in BUS_REQ / BUS_RSP
//   bad_ch_o : start_ch_i is not an existing channel (combinational)
//   acc_o    : read request accepted, parent moves to BUS_RSP
//   done_o   : op finished (ok, timeout or bad channel), parent -> IDLE
//   err_o    : op finished with timeout or bad channel
//   rdata_o  : read data, all ones unless a real response arrived
module cpu_bus_master
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = 4,
    parameter int BUS_TIMEOUT = 255,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              start_write_i,
    input  logic [CH_W-1:0]   start_ch_i,
    input  logic [DATA_W-1:0] start_data_i,
    input  logic              in_req_i,
    input  logic              in_rsp_i,
    output logic              bad_ch_o,
    output logic              acc_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    cpu_memwb_unit_if.master  bus
);
    localparam int TO_W = $clog2(BUS_TIMEOUT + 1);

    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bad_q, bad_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic hs, cnt_last, req_tmo, rsp_hit, rsp_tmo;

    assign bad_ch_o = int'(start_ch_i) >= NUM_CH;

    assign hs       = valid_q && bus.bus_req_ready;
    assign cnt_last = (cnt_q == TO_W'(BUS_TIMEOUT - 1));
    assign req_tmo  = in_req_i && !bad_q && !hs && cnt_last;
    assign rsp_hit  = in_rsp_i && bus.bus_rsp_valid;
    assign rsp_tmo  = in_rsp_i && !bus.bus_rsp_valid && cnt_last;

    assign acc_o   = in_req_i && hs && !write_q;
    assign done_o  = (in_req_i && (bad_q || req_tmo || (hs && write_q))) || rsp_hit || rsp_tmo;
    assign err_o   = (in_req_i && (bad_q || req_tmo)) || rsp_tmo;
    assign rdata_o = rsp_hit ? bus.bus_rsp_data : '1;

    always_comb begin
        valid_d = valid_q;
        write_d = write_q;
        ch_d    = ch_q;
        data_d  = data_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            // A bad channel never raises valid; the parent completes it
            // on the next cycle.
            valid_d = !bad_ch_o;
            write_d = start_write_i;
            ch_d    = start_ch_i;
            data_d  = start_data_i;
            bad_d   = bad_ch_o;
            cnt_d   = '0;
        end else if (in_req_i) begin
            if (hs || req_tmo || bad_q) begin
                valid_d = 1'b0;
                cnt_d   = '0;   // restarts the count for BUS_RSP
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (in_rsp_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bus_req_valid = valid_q;
    assign bus.bus_req_write = write_q;
    assign bus.bus_req_ch    = ch_q;
    assign bus.bus_req_data  = data_q;

endmodule

// File: rtl/cpu_memwb_unit.sv
// CPU memory/writeback stage. Accepts one instruction from EX when idle,
// performs ALU writeback, BRAM load/store or accelerator bus read/write,
// and drives the register-file write port plus a one-cycle-old copy of it
// for forwarding.
//   clk, rst                  : clock, synchronous active-high reset
//   ex_*                      : instruction from EX; ex_ready low stalls EX
//   dmem_*                    : data BRAM port (read latency MEM_LAT)
//   bus                       : accelerator bus (master side)
//   wb_*, prev_wb_*           : writeback port and its delayed copy
//   bus_err                   : sticky bus timeout / bad-channel flag
//   state_o                   : current FSM state
module cpu_memwb_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int NUM_CH      = 4,
    parameter int MEM_LAT     = 1,
    parameter int BUS_TIMEOUT = 255,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_bustoreg,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_buswrite,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_src2_data,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [CH_W-1:0]   ex_ch,
    output logic              dmem_ren,
    output logic              dmem_wren,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_data_to,
    input  logic [DATA_W-1:0] dmem_data_from,
    cpu_memwb_unit_if.master  bus,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              prev_wb_en,
    output logic [REG_AW-1:0] prev_wb_dest,
    output logic [DATA_W-1:0] prev_wb_data,
    output logic              bus_err,
    output memwb_state_t      state_o
);
    memwb_state_t      state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              ren_q, ren_d, wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              busrd_q, busrd_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              prev_en_q;
    logic [REG_AW-1:0] prev_dest_q;
    logic [DATA_W-1:0] prev_data_q;
    logic              err_q, err_d;

    op_class_t         op;
    logic              accept, bm_start;
    logic              bm_bad, bm_acc, bm_done, bm_err;
    logic [DATA_W-1:0] bm_rdata;

    // A load always writes back memory data here, so memtoreg adds nothing.
    logic unused_flags;
    assign unused_flags = ex_memtoreg;

    assign op       = decode_op(ex_regwrite, ex_memread, ex_memwrite, ex_bustoreg, ex_buswrite);
    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign bm_start = accept && (op == OP_BUSRD || op == OP_BUSWR);

    cpu_bus_master #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .BUS_TIMEOUT(BUS_TIMEOUT), .CH_W(CH_W)
    ) u_bus_master (
        .clk          (clk),
        .rst          (rst),
        .start_i      (bm_start),
        .start_write_i(op == OP_BUSWR),
        .start_ch_i   (ex_ch),
        .start_data_i (ex_src2_data),
        .in_req_i     (state_q == BUS_REQ),
        .in_rsp_i     (state_q == BUS_RSP),
        .bad_ch_o     (bm_bad),
        .acc_o        (bm_acc),
        .done_o       (bm_done),
        .err_o        (bm_err),
        .rdata_o      (bm_rdata),
        .bus          (bus)
    );

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        ren_d     = 1'b0;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        dest_d    = dest_q;
        busrd_d   = busrd_q;
        wb_en_d   = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dest_d = ex_dest;
                    case (op)
                        OP_ALU: begin
                            wb_en_d   = 1'b1;
                            wb_dest_d = ex_dest;
                            wb_data_d = ex_alu_out;
                        end
                        OP_STORE: begin
                            wren_d  = 1'b1;
                            addr_d  = ex_alu_out[ADDR_W-1:0];
                            sdata_d = ex_src2_data;
                        end
                        OP_LOAD: begin
                            ren_d   = 1'b1;
                            addr_d  = ex_alu_out[ADDR_W-1:0];
                            lat_d   = '0;
                            state_d = LOAD_WAIT;
                        end
                        OP_BUSRD, OP_BUSWR: begin
                            busrd_d = (op == OP_BUSRD);
                            state_d = BUS_REQ;
                            if (bm_bad) err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_WAIT: begin
                // lat_q counts cycles since the ren cycle; data is valid
                // once it reaches MEM_LAT.
                if (lat_q == 3'(MEM_LAT)) begin
                    wb_en_d   = 1'b1;
                    wb_dest_d = dest_q;
                    wb_data_d = dmem_data_from;
                    state_d   = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            BUS_REQ, BUS_RSP: begin
                if (bm_done) begin
                    state_d = IDLE;
                    if (bm_err) err_d = 1'b1;
                    if (busrd_q) begin
                        wb_en_d   = 1'b1;
                        wb_dest_d = dest_q;
                        wb_data_d = bm_rdata;
                    end
                end else if (bm_acc) begin
                    state_d = BUS_RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            ren_q       <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            sdata_q     <= '0;
            dest_q      <= '0;
            busrd_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_data_q   <= '0;
            prev_en_q   <= 1'b0;
            prev_dest_q <= '0;
            prev_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            ren_q       <= ren_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            dest_q      <= dest_d;
            busrd_q     <= busrd_d;
            wb_en_q     <= wb_en_d;
            wb_dest_q   <= wb_dest_d;
            wb_data_q   <= wb_data_d;
            prev_en_q   <= wb_en_q;
            prev_dest_q <= wb_dest_q;
            prev_data_q <= wb_data_q;
            err_q       <= err_d;
        end
    end

    assign dmem_ren     = ren_q;
    assign dmem_wren    = wren_q;
    assign dmem_addr    = addr_q;
    assign dmem_data_to = sdata_q;
    assign wb_en        = wb_en_q;
    assign wb_dest      = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign prev_wb_en   = prev_en_q;
    assign prev_wb_dest = prev_dest_q;
    assign prev_wb_data = prev_data_q;
    assign bus_err      = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cpu_memwb_unit.sv
module tb_cpu_memwb_unit;
  import cpu_pkg::*;

  // Five channels so that channel 5 is representable and out of range.
  localparam int NUM_CH = 5;
  localparam int CH_W   = 3;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
  localparam int TMO    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared EX inputs ----------------
  logic ex_valid_a, ex_valid_b;
  logic ex_regwrite, ex_memtoreg, ex_bustoreg, ex_memread, ex_memwrite, ex_buswrite;
  logic [15:0] ex_alu_out, ex_src2_data;
  logic [3:0]  ex_dest;
  logic [CH_W-1:0] ex_ch;

  // ---------------- DUT A (MEM_LAT=1) ----------------
  logic ex_ready_a, dmem_ren_a, dmem_wren_a, wb_en_a, prev_wb_en_a, bus_err_a;
  logic [15:0] dmem_addr_a, dmem_data_to_a, dmem_data_from_a, wb_data_a, prev_wb_data_a;
  logic [3:0]  wb_dest_a, prev_wb_dest_a;
  memwb_state_t state_a;
  cpu_memwb_unit_if #(.DATA_W(16), .CH_W(CH_W)) if_a ();

  cpu_memwb_unit #(.NUM_CH(NUM_CH), .MEM_LAT(LAT_A), .BUS_TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_a), .ex_ready(ex_ready_a),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_bustoreg(ex_bustoreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_buswrite(ex_buswrite),
    .ex_alu_out(ex_alu_out), .ex_src2_data(ex_src2_data), .ex_dest(ex_dest), .ex_ch(ex_ch),
    .dmem_ren(dmem_ren_a), .dmem_wren(dmem_wren_a), .dmem_addr(dmem_addr_a),
    .dmem_data_to(dmem_data_to_a), .dmem_data_from(dmem_data_from_a), .bus(if_a),
    .wb_en(wb_en_a), .wb_dest(wb_dest_a), .wb_data(wb_data_a),
    .prev_wb_en(prev_wb_en_a), .prev_wb_dest(prev_wb_dest_a), .prev_wb_data(prev_wb_data_a),
    .bus_err(bus_err_a), .state_o(state_a)
  );

  // ---------------- DUT B (MEM_LAT=3) ----------------
  logic ex_ready_b, dmem_ren_b, dmem_wren_b, wb_en_b, prev_wb_en_b, bus_err_b;
  logic [15:0] dmem_addr_b, dmem_data_to_b, dmem_data_from_b, wb_data_b, prev_wb_data_b;
  logic [3:0]  wb_dest_b, prev_wb_dest_b;
  memwb_state_t state_b;
  cpu_memwb_unit_if #(.DATA_W(16), .CH_W(CH_W)) if_b ();

  cpu_memwb_unit #(.NUM_CH(NUM_CH), .MEM_LAT(LAT_B), .BUS_TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_b), .ex_ready(ex_ready_b),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_bustoreg(ex_bustoreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_buswrite(ex_buswrite),
    .ex_alu_out(ex_alu_out), .ex_src2_data(ex_src2_data), .ex_dest(ex_dest), .ex_ch(ex_ch),
    .dmem_ren(dmem_ren_b), .dmem_wren(dmem_wren_b), .dmem_addr(dmem_addr_b),
    .dmem_data_to(dmem_data_to_b), .dmem_data_from(dmem_data_from_b), .bus(if_b),
    .wb_en(wb_en_b), .wb_dest(wb_dest_b), .wb_data(wb_data_b),
    .prev_wb_en(prev_wb_en_b), .prev_wb_dest(prev_wb_dest_b), .prev_wb_data(prev_wb_data_b),
    .bus_err(bus_err_b), .state_o(state_b)
  );

  // ---------------- BRAM models: data valid only MEM_LAT cycles after ren ----------------
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [7:0]  pa_addr [1:4];
  logic        pa_v    [1:4];
  logic [7:0]  pb_addr [1:4];
  logic        pb_v    [1:4];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] <= 16'h0000;
        mem_b[k] <= 16'h0000;
      end
      mem_a[8'h40] <= 16'hBEEF;
      mem_b[8'h40] <= 16'hBEEF;
      for (int k = 1; k <= 4; k++) begin
        pa_v[k] <= 1'b0; pa_addr[k] <= 8'h00;
        pb_v[k] <= 1'b0; pb_addr[k] <= 8'h00;
      end
    end else begin
      if (dmem_wren_a) mem_a[dmem_addr_a[7:0]] <= dmem_data_to_a;
      if (dmem_wren_b) mem_b[dmem_addr_b[7:0]] <= dmem_data_to_b;
      pa_v[1] <= dmem_ren_a; pa_addr[1] <= dmem_addr_a[7:0];
      pb_v[1] <= dmem_ren_b; pb_addr[1] <= dmem_addr_b[7:0];
      for (int k = 2; k <= 4; k++) begin
        pa_v[k] <= pa_v[k-1]; pa_addr[k] <= pa_addr[k-1];
        pb_v[k] <= pb_v[k-1]; pb_addr[k] <= pb_addr[k-1];
      end
    end
  end

  assign dmem_data_from_a = pa_v[LAT_A] ? mem_a[pa_addr[LAT_A]] : 16'hDEAD;
  assign dmem_data_from_b = pb_v[LAT_B] ? mem_b[pb_addr[LAT_B]] : 16'hDEAD;

  // ---------------- scoreboard counters / checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid_a = 1'b0; ex_valid_b = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_bustoreg = 1'b0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_buswrite = 1'b0;
    ex_alu_out = 16'h0; ex_src2_data = 16'h0; ex_dest = 4'h0; ex_ch = '0;
  endtask

  // Load on DUT A or B; extra=1 also raises lower-priority flags.
  task automatic do_load(input bit on_b, input int lat, input logic [15:0] addr,
                         input logic [3:0] dest, input logic [15:0] exp, input bit extra);
    clear_ex();
    ex_memread = 1'b1; ex_memtoreg = 1'b1; ex_alu_out = addr; ex_dest = dest;
    if (extra) begin
      ex_memwrite = 1'b1; ex_bustoreg = 1'b1; ex_regwrite = 1'b1;
    end
    if (on_b) ex_valid_b = 1'b1; else ex_valid_a = 1'b1;
    tick();
    clear_ex();
    chk("ld_ren",     on_b ? dmem_ren_b : dmem_ren_a, 1);
    chk("ld_addr",    on_b ? dmem_addr_b : dmem_addr_a, addr);
    chk("ld_stall",   on_b ? ex_ready_b : ex_ready_a, 0);
    chk("ld_no_wren", on_b ? dmem_wren_b : dmem_wren_a, 0);
    chk("ld_no_req",  on_b ? if_b.bus_req_valid : if_a.bus_req_valid, 0);
    chk("ld_no_wb0",  on_b ? wb_en_b : wb_en_a, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("ld_ren_once", on_b ? dmem_ren_b : dmem_ren_a, 0);
      chk("ld_addr_hold", on_b ? dmem_addr_b : dmem_addr_a, addr);
      chk("ld_wait_nowb", on_b ? wb_en_b : wb_en_a, 0);
      chk("ld_wait_stall", on_b ? ex_ready_b : ex_ready_a, 0);
    end
    tick();
    chk("ld_wb_en",   on_b ? wb_en_b : wb_en_a, 1);
    chk("ld_wb_data", on_b ? wb_data_b : wb_data_a, exp);
    chk("ld_wb_dest", on_b ? wb_dest_b : wb_dest_a, dest);
    chk("ld_ready",   on_b ? ex_ready_b : ex_ready_a, 1);
    tick();
    chk("ld_wb_once", on_b ? wb_en_b : wb_en_a, 0);
  endtask

  // Bus read to channel 5 (out of range): no request, all-ones writeback.
  task automatic bad_ch_read(input bit on_b, input logic [3:0] dest);
    clear_ex();
    ex_bustoreg = 1'b1; ex_ch = 3'd5; ex_dest = dest;
    if (on_b) ex_valid_b = 1'b1; else ex_valid_a = 1'b1;
    tick();
    clear_ex();
    chk("bad_no_req",  on_b ? if_b.bus_req_valid : if_a.bus_req_valid, 0);
    chk("bad_err",     on_b ? bus_err_b : bus_err_a, 1);
    chk("bad_nowb_n1", on_b ? wb_en_b : wb_en_a, 0);
    tick();
    chk("bad_no_req2", on_b ? if_b.bus_req_valid : if_a.bus_req_valid, 0);
    chk("bad_wb_en",   on_b ? wb_en_b : wb_en_a, 1);
    chk("bad_wb_data", on_b ? wb_data_b : wb_data_a, 16'hFFFF);
    chk("bad_wb_dest", on_b ? wb_dest_b : wb_dest_a, dest);
    chk("bad_ready",   on_b ? ex_ready_b : ex_ready_a, 1);
    tick();
    chk("bad_err_sticky", on_b ? bus_err_b : bus_err_a, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  alu_dest [3];
  logic [15:0] alu_val  [3];
  int vcnt;
  bit seen_wb;

  initial begin
    clear_ex();
    if_a.bus_req_ready = 1'b0; if_a.bus_rsp_valid = 1'b0; if_a.bus_rsp_data = 16'h0;
    if_b.bus_req_ready = 1'b0; if_b.bus_rsp_valid = 1'b0; if_b.bus_rsp_data = 16'h0;
    alu_dest[0] = 4'd1; alu_dest[1] = 4'd2; alu_dest[2] = 4'd3;
    alu_val[0] = 16'h0011; alu_val[1] = 16'h0022; alu_val[2] = 16'h0033;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready",   ex_ready_a, 1);
    chk("rst_wb_en",   wb_en_a, 0);
    chk("rst_ren",     dmem_ren_a, 0);
    chk("rst_wren",    dmem_wren_a, 0);
    chk("rst_req",     if_a.bus_req_valid, 0);
    chk("rst_err",     bus_err_a, 0);
    chk("rst_prev_en", prev_wb_en_a, 0);
    chk("rst_ready_b", ex_ready_b, 1);
    rst = 1'b0;
    tick();

    // three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      clear_ex();
      ex_valid_a = 1'b1; ex_regwrite = 1'b1; ex_dest = alu_dest[i]; ex_alu_out = alu_val[i];
      tick();
      chk("alu_wb_en",   wb_en_a, 1);
      chk("alu_wb_dest", wb_dest_a, alu_dest[i]);
      chk("alu_wb_data", wb_data_a, alu_val[i]);
      chk("alu_ready",   ex_ready_a, 1);
      if (i == 0) begin
        chk("alu_prev_en0", prev_wb_en_a, 0);
      end else begin
        chk("alu_prev_en",   prev_wb_en_a, 1);
        chk("alu_prev_dest", prev_wb_dest_a, alu_dest[i-1]);
        chk("alu_prev_data", prev_wb_data_a, alu_val[i-1]);
      end
    end
    clear_ex();
    tick();
    chk("alu_wb_off",     wb_en_a, 0);
    chk("alu_prev_last",  prev_wb_en_a, 1);
    chk("alu_prev_dest3", prev_wb_dest_a, 4'd3);
    chk("alu_prev_data3", prev_wb_data_a, 16'h0033);
    tick();
    chk("alu_prev_zero",  prev_wb_en_a, 0);

    // loads with MEM_LAT=1 (priority flags raised) and MEM_LAT=3
    do_load(1'b0, LAT_A, 16'h0040, 4'd5, 16'hBEEF, 1'b1);
    do_load(1'b1, LAT_B, 16'h0040, 4'd6, 16'hBEEF, 1'b0);

    // store wins over bus and ALU flags, then load it back
    clear_ex();
    ex_valid_a = 1'b1; ex_memwrite = 1'b1; ex_bustoreg = 1'b1; ex_buswrite = 1'b1;
    ex_regwrite = 1'b1; ex_alu_out = 16'h0010; ex_src2_data = 16'h1234; ex_dest = 4'd4;
    tick();
    clear_ex();
    chk("st_wren",   dmem_wren_a, 1);
    chk("st_addr",   dmem_addr_a, 16'h0010);
    chk("st_data",   dmem_data_to_a, 16'h1234);
    chk("st_no_wb",  wb_en_a, 0);
    chk("st_no_req", if_a.bus_req_valid, 0);
    chk("st_ready",  ex_ready_a, 1);
    tick();
    chk("st_wren_once", dmem_wren_a, 0);
    do_load(1'b0, LAT_A, 16'h0010, 4'd4, 16'h1234, 1'b0);

    // reset while in LOAD_WAIT
    clear_ex();
    ex_valid_a = 1'b1; ex_memread = 1'b1; ex_alu_out = 16'h0040; ex_dest = 4'd8;
    tick();
    clear_ex();
    chk("rl_ren", dmem_ren_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rl_ren_off", dmem_ren_a, 0);
    chk("rl_wb_off",  wb_en_a, 0);
    chk("rl_ready",   ex_ready_a, 1);
    seen_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_en_a) seen_wb = 1'b1;
    end
    chk("rl_never_wb", seen_wb, 0);

    // bus read ch 2: ready after 4 waiting cycles, response 2 cycles later
    clear_ex();
    ex_valid_a = 1'b1; ex_bustoreg = 1'b1; ex_ch = 3'd2; ex_dest = 4'd7; ex_src2_data = 16'h5555;
    tick();
    clear_ex();
    for (int i = 0; i < 4; i++) begin
      chk("brd_valid", if_a.bus_req_valid, 1);
      chk("brd_ch",    if_a.bus_req_ch, 3'd2);
      chk("brd_write", if_a.bus_req_write, 0);
      chk("brd_data",  if_a.bus_req_data, 16'h5555);
      chk("brd_stall", ex_ready_a, 0);
      chk("brd_nowb",  wb_en_a, 0);
      // a response during the request phase must be ignored
      if (i == 1) begin
        if_a.bus_rsp_valid = 1'b1; if_a.bus_rsp_data = 16'h1111;
      end else begin
        if_a.bus_rsp_valid = 1'b0;
      end
      tick();
    end
    if_a.bus_req_ready = 1'b1;
    chk("brd_valid_hs", if_a.bus_req_valid, 1);
    tick();
    if_a.bus_req_ready = 1'b0;
    chk("brd_valid_drop", if_a.bus_req_valid, 0);
    chk("brd_rsp_stall",  ex_ready_a, 0);
    chk("brd_rsp_nowb",   wb_en_a, 0);
    tick();
    chk("brd_rsp_nowb2",  wb_en_a, 0);
    if_a.bus_rsp_valid = 1'b1; if_a.bus_rsp_data = 16'hA5A5;
    tick();
    if_a.bus_rsp_valid = 1'b0; if_a.bus_rsp_data = 16'h0000;
    chk("brd_wb_en",   wb_en_a, 1);
    chk("brd_wb_data", wb_data_a, 16'hA5A5);
    chk("brd_wb_dest", wb_dest_a, 4'd7);
    chk("brd_ready",   ex_ready_a, 1);
    tick();
    chk("brd_wb_once", wb_en_a, 0);
    chk("brd_no_err",  bus_err_a, 0);

    // bus write ch 1, ready never comes: timeout after TMO cycles
    clear_ex();
    ex_valid_a = 1'b1; ex_buswrite = 1'b1; ex_ch = 3'd1; ex_src2_data = 16'hCAFE; ex_dest = 4'd2;
    tick();
    clear_ex();
    chk("bwr_write", if_a.bus_req_write, 1);
    chk("bwr_ch",    if_a.bus_req_ch, 3'd1);
    chk("bwr_data",  if_a.bus_req_data, 16'hCAFE);
    vcnt = 0;
    seen_wb = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (if_a.bus_req_valid) vcnt++;
      if (wb_en_a) seen_wb = 1'b1;
      tick();
    end
    chk("bwr_valid_cycles", vcnt, TMO);
    chk("bwr_no_wb",        seen_wb, 0);
    chk("bwr_err",          bus_err_a, 1);
    chk("bwr_ready",        ex_ready_a, 1);
    chk("bwr_valid_off",    if_a.bus_req_valid, 0);

    // bad channel read: B has no prior error, A keeps its sticky one
    chk("bad_err_before_b", bus_err_b, 0);
    bad_ch_read(1'b1, 4'd9);
    bad_ch_read(1'b0, 4'd10);

    // reset mid-handshake drops valid and clears bus_err
    clear_ex();
    ex_valid_a = 1'b1; ex_buswrite = 1'b1; ex_ch = 3'd1; ex_src2_data = 16'h0F0F;
    tick();
    clear_ex();
    chk("rh_valid", if_a.bus_req_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_valid_off", if_a.bus_req_valid, 0);
    chk("rh_err_clr",   bus_err_a, 0);
    chk("rh_ready",     ex_ready_a, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
